pipeline_ctrl: RTL and testbench

//  Central stall/flush scheduler for the 5-stage pipeline. Combines these inputs into per-stage

---
 rtl/pipeline_ctrl_pkg.sv | 42 ++++
 rtl/pipeline_ctrl_if.sv | 37 +++
 rtl/pipeline_ctrl_sat_counter.sv | 23 ++
 rtl/pipeline_ctrl.sv | 132 +++++++++++++
 tb/tb_pipeline_ctrl.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_ctrl_pkg.sv
// Shared types for the pipeline stall/flush scheduler: FSM states, stage-control bundle
// and the canned control patterns used by the top-level evaluation.
package pipeline_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_MWAIT = 2'd1,
        ST_HALT  = 2'd2
    } state_t;

    // Instruction word the stage registers load on a flush (addi x0,x0,0).
    localparam logic [31:0] NOP_INSN = 32'h0000_0013;

    typedef struct packed {
        logic pc_we;
        logic npc_sel;
        logic ifid_we;
        logic ifid_flush;
        logic idex_we;
        logic idex_flush;
        logic exmem_we;
        logic memwb_flush;
    } ctrl_t;

    function automatic ctrl_t ctrl_advance();
        ctrl_t c;
        c          = '0;
        c.pc_we    = 1'b1;
        c.ifid_we  = 1'b1;
        c.idex_we  = 1'b1;
        c.exmem_we = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t ctrl_freeze();
        ctrl_t c;
        c             = '0;
        c.memwb_flush = 1'b1;
        return c;
    endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Hazard/branch/memory inputs and stage-control outputs of the pipeline scheduler.
interface pipeline_ctrl_if #(
    parameter int unsigned CNT_W = 32
);
    logic             ld_use_hz;
    logic             ex_valid;
    logic             ex_br_taken;
    logic [31:0]      ex_br_target;
    logic             mem_req;
    logic             mem_ack;

    logic             pc_we;
    logic             npc_sel;
    logic [31:0]      redir_pc;
    logic             ifid_we;
    logic             ifid_flush;
    logic             idex_we;
    logic             idex_flush;
    logic             exmem_we;
    logic             memwb_flush;
    logic             bus_err;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        input  ld_use_hz, ex_valid, ex_br_taken, ex_br_target, mem_req, mem_ack,
        output pc_we, npc_sel, redir_pc, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, memwb_flush, bus_err, stall_cnt, flush_cnt
    );

    modport slave (
        output ld_use_hz, ex_valid, ex_br_taken, ex_br_target, mem_req, mem_ack,
        input  pc_we, npc_sel, redir_pc, ifid_we, ifid_flush, idex_we, idex_flush,
               exmem_we, memwb_flush, bus_err, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + W'(1);
        end
    end

    assign count = r_count;

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush scheduler for the 5-stage pipeline: per-stage enables, bubbles, PC redirect,
// memory-wait watchdog and saturating stall/flush counters.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter int unsigned WAIT_TIMEOUT = 16,
    parameter int unsigned CNT_W        = 32
) (
    input  logic            clk,
    input  logic            rst,
    pipeline_ctrl_if.master ctl
);

    state_t       r_state;
    state_t       w_state_nxt;
    logic [7:0]   r_wait_cnt;
    logic [7:0]   w_wait_nxt;
    logic         r_bus_err;
    logic         w_bus_err_nxt;
    ctrl_t        w_ctrl;
    ctrl_t        w_ctrl_out;
    logic         w_eval;
    logic         w_stall_inc;
    logic         w_flush_inc;
    logic [CNT_W-1:0] w_stall_cnt;
    logic [CNT_W-1:0] w_flush_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_RUN;
            r_wait_cnt <= '0;
            r_bus_err  <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_wait_cnt <= w_wait_nxt;
            r_bus_err  <= w_bus_err_nxt;
        end
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_wait_nxt    = r_wait_cnt;
        w_bus_err_nxt = r_bus_err;
        w_ctrl        = ctrl_advance();
        w_eval        = 1'b0;
        w_stall_inc   = 1'b0;
        w_flush_inc   = 1'b0;

        unique case (r_state)
            ST_RUN: begin
                if (ctl.mem_req && !ctl.mem_ack) begin
                    w_ctrl      = ctrl_freeze();
                    w_stall_inc = 1'b1;
                    w_state_nxt = ST_MWAIT;
                    w_wait_nxt  = 8'd1;
                end else begin
                    w_eval = 1'b1;
                end
            end
            ST_MWAIT: begin
                if (!ctl.mem_ack) begin
                    w_ctrl      = ctrl_freeze();
                    w_stall_inc = 1'b1;
                    if (r_wait_cnt == 8'(WAIT_TIMEOUT)) begin
                        w_bus_err_nxt = 1'b1;
                        w_state_nxt   = ST_HALT;
                    end else begin
                        w_wait_nxt = r_wait_cnt + 8'd1;
                    end
                end else begin
                    // Ack cycle reuses the RUN evaluation so a branch parked in EX redirects now.
                    w_eval      = 1'b1;
                    w_state_nxt = ST_RUN;
                    w_wait_nxt  = '0;
                end
            end
            ST_HALT: begin
                w_ctrl = ctrl_freeze();
            end
            default: begin
                w_ctrl      = ctrl_freeze();
                w_state_nxt = ST_RUN;
                w_wait_nxt  = '0;
            end
        endcase

        if (w_eval) begin
            if (ctl.ex_valid && ctl.ex_br_taken) begin
                w_ctrl.npc_sel    = 1'b1;
                w_ctrl.ifid_flush = 1'b1;
                w_ctrl.idex_flush = 1'b1;
                w_flush_inc       = 1'b1;
            end else if (ctl.ld_use_hz) begin
                w_ctrl.pc_we      = 1'b0;
                w_ctrl.ifid_we    = 1'b0;
                w_ctrl.idex_flush = 1'b1;
                w_stall_inc       = 1'b1;
            end
        end
    end

    assign w_ctrl_out = rst ? ctrl_t'('0) : w_ctrl;

    assign ctl.pc_we       = w_ctrl_out.pc_we;
    assign ctl.npc_sel     = w_ctrl_out.npc_sel;
    assign ctl.redir_pc    = w_ctrl_out.npc_sel ? ctl.ex_br_target : '0;
    assign ctl.ifid_we     = w_ctrl_out.ifid_we;
    assign ctl.ifid_flush  = w_ctrl_out.ifid_flush;
    assign ctl.idex_we     = w_ctrl_out.idex_we;
    assign ctl.idex_flush  = w_ctrl_out.idex_flush;
    assign ctl.exmem_we    = w_ctrl_out.exmem_we;
    assign ctl.memwb_flush = w_ctrl_out.memwb_flush;
    assign ctl.bus_err     = r_bus_err;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_stall_inc),
        .count (w_stall_cnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_flush_inc),
        .count (w_flush_cnt)
    );

    assign ctl.stall_cnt = w_stall_cnt;
    assign ctl.flush_cnt = w_flush_cnt;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with a short watchdog and 4-bit counters.
module tb_pipeline_ctrl;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    pipeline_ctrl_if #(.CNT_W(4)) bus ();

    pipeline_ctrl #(
        .WAIT_TIMEOUT (4),
        .CNT_W        (4)
    ) dut (
        .clk (clk),
        .rst (rst),
        .ctl (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp_v);
        n_checks++;
        if (got !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp_v);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_in();
        bus.ld_use_hz    = 1'b0;
        bus.ex_valid     = 1'b0;
        bus.ex_br_taken  = 1'b0;
        bus.ex_br_target = '0;
        bus.mem_req      = 1'b0;
        bus.mem_ack      = 1'b0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        clear_in();
        bus.ex_valid     = 1'b1;
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 32'h0000_0040;
        #3;
        check_eq("rst_pc_we", bus.pc_we, 0);
        check_eq("rst_exmem_we", bus.exmem_we, 0);
        check_eq("rst_npc_sel", bus.npc_sel, 0);
        check_eq("rst_redir", bus.redir_pc, 0);
        check_eq("rst_ifid_flush", bus.ifid_flush, 0);
        check_eq("rst_stall", bus.stall_cnt, 0);
        check_eq("rst_bus_err", bus.bus_err, 0);
        step();
        rst = 1'b0;
        clear_in();
        step();
        #2;
        check_eq("run_pc_we", bus.pc_we, 1);
        check_eq("run_ifid_we", bus.ifid_we, 1);
        check_eq("run_idex_we", bus.idex_we, 1);
        check_eq("run_exmem_we", bus.exmem_we, 1);
        check_eq("run_flush_cnt", bus.flush_cnt, 0);

        // Load-use bubble
        step();
        bus.ld_use_hz = 1'b1;
        #2;
        check_eq("lu_pc_we", bus.pc_we, 0);
        check_eq("lu_ifid_we", bus.ifid_we, 0);
        check_eq("lu_idex_flush", bus.idex_flush, 1);
        check_eq("lu_exmem_we", bus.exmem_we, 1);
        check_eq("lu_memwb_flush", bus.memwb_flush, 0);
        step();
        bus.ld_use_hz = 1'b0;
        #2;
        check_eq("lu_stall_cnt", bus.stall_cnt, 1);
        check_eq("lu_after_pc_we", bus.pc_we, 1);
        check_eq("lu_after_ifid_we", bus.ifid_we, 1);
        check_eq("lu_after_idex_flush", bus.idex_flush, 0);

        // Taken branch beats a same-cycle load-use
        step();
        bus.ex_valid     = 1'b1;
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 32'h0000_0040;
        bus.ld_use_hz    = 1'b1;
        #2;
        check_eq("br_npc_sel", bus.npc_sel, 1);
        check_eq("br_redir", bus.redir_pc, 32'h0000_0040);
        check_eq("br_ifid_flush", bus.ifid_flush, 1);
        check_eq("br_idex_flush", bus.idex_flush, 1);
        check_eq("br_pc_we", bus.pc_we, 1);
        step();
        clear_in();
        #2;
        check_eq("br_flush_cnt", bus.flush_cnt, 1);
        check_eq("br_stall_cnt", bus.stall_cnt, 1);
        check_eq("br_after_npc_sel", bus.npc_sel, 0);
        check_eq("br_after_redir", bus.redir_pc, 0);

        // Taken without ex_valid is a bubble: no redirect
        step();
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 32'h0000_0040;
        #2;
        check_eq("nv_npc_sel", bus.npc_sel, 0);
        check_eq("nv_redir", bus.redir_pc, 0);
        step();
        clear_in();
        #2;
        check_eq("nv_flush_cnt", bus.flush_cnt, 1);

        // Memory wait: 3 freeze cycles, release on ack
        step();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #2;
            check_eq("mw_pc_we", bus.pc_we, 0);
            check_eq("mw_ifid_we", bus.ifid_we, 0);
            check_eq("mw_exmem_we", bus.exmem_we, 0);
            check_eq("mw_memwb_flush", bus.memwb_flush, 1);
            step();
        end
        bus.mem_ack = 1'b1;
        #2;
        check_eq("mw_ack_pc_we", bus.pc_we, 1);
        check_eq("mw_ack_memwb_flush", bus.memwb_flush, 0);
        check_eq("mw_stall_cnt", bus.stall_cnt, 4);
        step();
        clear_in();
        #2;
        check_eq("mw_run_pc_we", bus.pc_we, 1);
        check_eq("mw_run_stall_cnt", bus.stall_cnt, 4);

        // Same-cycle req+ack and stray ack: no stall
        step();
        bus.mem_req = 1'b1;
        bus.mem_ack = 1'b1;
        #2;
        check_eq("ra_pc_we", bus.pc_we, 1);
        check_eq("ra_memwb_flush", bus.memwb_flush, 0);
        step();
        bus.mem_req = 1'b0;
        #2;
        check_eq("ack_only_pc_we", bus.pc_we, 1);
        step();
        clear_in();
        #2;
        check_eq("ra_stall_cnt", bus.stall_cnt, 4);

        // Branch held in EX across a 2-cycle wait redirects on the ack cycle
        step();
        bus.mem_req      = 1'b1;
        bus.ex_valid     = 1'b1;
        bus.ex_br_taken  = 1'b1;
        bus.ex_br_target = 32'h0000_0080;
        for (int i = 0; i < 2; i++) begin
            #2;
            check_eq("wb_npc_sel", bus.npc_sel, 0);
            check_eq("wb_pc_we", bus.pc_we, 0);
            check_eq("wb_redir", bus.redir_pc, 0);
            step();
        end
        bus.mem_ack = 1'b1;
        #2;
        check_eq("wb_ack_npc_sel", bus.npc_sel, 1);
        check_eq("wb_ack_redir", bus.redir_pc, 32'h0000_0080);
        check_eq("wb_ack_ifid_flush", bus.ifid_flush, 1);
        check_eq("wb_ack_pc_we", bus.pc_we, 1);
        step();
        clear_in();
        #2;
        check_eq("wb_flush_cnt", bus.flush_cnt, 2);
        check_eq("wb_stall_cnt", bus.stall_cnt, 6);

        // Stall counter saturates at 4'hF
        step();
        bus.ld_use_hz = 1'b1;
        for (int i = 0; i < 12; i++) step();
        bus.ld_use_hz = 1'b0;
        #2;
        check_eq("sat_stall_cnt", bus.stall_cnt, 4'hF);

        // Reset asserted mid-wait aborts to RUN
        step();
        bus.mem_req = 1'b1;
        step();
        step();
        #2;
        check_eq("rw_frozen_pc_we", bus.pc_we, 0);
        rst = 1'b1;
        #1;
        check_eq("rw_rst_memwb_flush", bus.memwb_flush, 0);
        check_eq("rw_rst_stall_cnt", bus.stall_cnt, 0);
        step();
        rst = 1'b0;
        clear_in();
        #2;
        check_eq("rw_run_pc_we", bus.pc_we, 1);
        check_eq("rw_run_memwb_flush", bus.memwb_flush, 0);

        // Watchdog: bus_err after 4 MWAIT cycles, then HALT ignores stimulus
        step();
        bus.mem_req = 1'b1;
        for (int i = 0; i < 4; i++) step();
        #2;
        check_eq("to_pre_bus_err", bus.bus_err, 0);
        check_eq("to_pre_pc_we", bus.pc_we, 0);
        step();
        #2;
        check_eq("to_bus_err", bus.bus_err, 1);
        for (int i = 0; i < 20; i++) begin
            bus.mem_req      = i[0];
            bus.mem_ack      = 1'b1;
            bus.ld_use_hz    = 1'b1;
            bus.ex_valid     = 1'b1;
            bus.ex_br_taken  = 1'b1;
            bus.ex_br_target = 32'h0000_00C0;
            #2;
            check_eq("halt_pc_we", bus.pc_we, 0);
            check_eq("halt_exmem_we", bus.exmem_we, 0);
            check_eq("halt_npc_sel", bus.npc_sel, 0);
            check_eq("halt_memwb_flush", bus.memwb_flush, 1);
            step();
        end
        check_eq("halt_bus_err", bus.bus_err, 1);
        rst = 1'b1;
        #1;
        check_eq("halt_rst_bus_err", bus.bus_err, 0);
        step();
        rst = 1'b0;
        clear_in();
        #2;
        check_eq("halt_rst_pc_we", bus.pc_we, 1);
        check_eq("halt_rst_flush_cnt", bus.flush_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
